// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register.
// Captures the decoded operands and control, forwards operands from EX/MEM and
// MEM/WB, and produces the ALU operands, the store data and the shift amount.
// It also inserts a bubble when a load's result is needed by the next instruction.
//
// Ports
//   clk, reset           clock; asynchronous active-high reset
//   stall, flush         global hold / squash
//   id_*                 decoded instruction fields and control from the decode stage
//   exm_*, wb_*          destination and result of the two downstream stages
//   id_stall             holds the PC and the IF/ID register
//   ex_valid, ex_rd      EX slot status and its destination register
//   ex_mem*/ex_reg*/ex_aluop  registered control, forced to 0 in a bubble
//   op_a, op_b           resolved ALU operands
//   store_data           resolved rt value for stores
//   sh_amt               shift amount for the barrel shifter
module id_ex_stage #(
   parameter int WIDTH   = 32,
   parameter int REGBITS = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic               id_valid,
   input  logic [REGBITS-1:0] id_rs,
   input  logic [REGBITS-1:0] id_rt,
   input  logic [REGBITS-1:0] id_rd,
   input  logic               id_uses_rs,
   input  logic               id_uses_rt,
   input  logic [WIDTH-1:0]   id_rs_data,
   input  logic [WIDTH-1:0]   id_rt_data,
   input  logic [15:0]        id_imm,
   input  logic [4:0]         id_shamt,
   input  logic               id_use_imm,
   input  logic               id_shift_var,
   input  logic               id_memread,
   input  logic               id_memwrite,
   input  logic               id_regwrite,
   input  logic               id_memtoreg,
   input  logic [2:0]         id_aluop,
   input  logic               exm_regwrite,
   input  logic [REGBITS-1:0] exm_rd,
   input  logic [WIDTH-1:0]   exm_result,
   input  logic               wb_regwrite,
   input  logic [REGBITS-1:0] wb_rd,
   input  logic [WIDTH-1:0]   wb_result,
   output logic               id_stall,
   output logic               ex_valid,
   output logic [REGBITS-1:0] ex_rd,
   output logic               ex_memread,
   output logic               ex_memwrite,
   output logic               ex_regwrite,
   output logic               ex_memtoreg,
   output logic [2:0]         ex_aluop,
   output logic [WIDTH-1:0]   op_a,
   output logic [WIDTH-1:0]   op_b,
   output logic [WIDTH-1:0]   store_data,
   output logic [4:0]         sh_amt
);

   logic [REGBITS-1:0] rs_q, rt_q;
   logic [WIDTH-1:0]   rs_data_q, rt_data_q;
   logic [15:0]        imm_q;
   logic [4:0]         shamt_q;
   logic               use_imm_q, shift_var_q;
   logic               memread_q, memwrite_q, regwrite_q, memtoreg_q;
   logic [2:0]         aluop_q;
   logic               load_use_hazard;
   logic               bubble;
   logic [WIDTH-1:0]   fwd_rs, fwd_rt;

   // Controls are gated so a bubble can never write state downstream.
   assign ex_memread  = ex_valid & memread_q;
   assign ex_memwrite = ex_valid & memwrite_q;
   assign ex_regwrite = ex_valid & regwrite_q;
   assign ex_memtoreg = ex_valid & memtoreg_q;
   assign ex_aluop    = ex_valid ? aluop_q : 3'd0;

   assign load_use_hazard = ex_valid & ex_memread & (ex_rd != '0) & id_valid &
                            ((id_uses_rs & (id_rs == ex_rd)) |
                             (id_uses_rt & (id_rt == ex_rd)));
   assign id_stall = stall | load_use_hazard;

   // A pending hazard under a global stall waits; the EX register holds,
   // so the hazard is still visible on the first unstalled edge.
   assign bubble = flush | (~stall & load_use_hazard);

   always_ff @(posedge clk or posedge reset) begin
      if (reset || bubble) begin
         ex_valid    <= 1'b0;
         ex_rd       <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
         shamt_q     <= '0;
         use_imm_q   <= 1'b0;
         shift_var_q <= 1'b0;
         memread_q   <= 1'b0;
         memwrite_q  <= 1'b0;
         regwrite_q  <= 1'b0;
         memtoreg_q  <= 1'b0;
         aluop_q     <= '0;
      end else if (!stall) begin
         ex_valid    <= id_valid;
         ex_rd       <= id_rd;
         rs_q        <= id_rs;
         rt_q        <= id_rt;
         rs_data_q   <= id_rs_data;
         rt_data_q   <= id_rt_data;
         imm_q       <= id_imm;
         shamt_q     <= id_shamt;
         use_imm_q   <= id_use_imm;
         shift_var_q <= id_shift_var;
         memread_q   <= id_memread;
         memwrite_q  <= id_memwrite;
         regwrite_q  <= id_regwrite;
         memtoreg_q  <= id_memtoreg;
         aluop_q     <= id_aluop;
      end
   end

   // The younger EX/MEM result takes precedence; r0 is never forwarded.
   always_comb begin
      fwd_rs = rs_data_q;
      if (exm_regwrite && (exm_rd != '0) && (exm_rd == rs_q))
         fwd_rs = exm_result;
      else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs_q))
         fwd_rs = wb_result;

      fwd_rt = rt_data_q;
      if (exm_regwrite && (exm_rd != '0) && (exm_rd == rt_q))
         fwd_rt = exm_result;
      else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rt_q))
         fwd_rt = wb_result;
   end

   assign op_a       = fwd_rs;
   assign store_data = fwd_rt;
   assign op_b       = use_imm_q ? {{(WIDTH-16){imm_q[15]}}, imm_q} : fwd_rt;
   assign sh_amt     = shift_var_q ? op_a[4:0] : shamt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_uses_rs, id_uses_rt;
   logic [31:0] id_rs_data, id_rt_data;
   logic [15:0] id_imm;
   logic [4:0]  id_shamt;
   logic        id_use_imm, id_shift_var, id_memread, id_memwrite, id_regwrite, id_memtoreg;
   logic [2:0]  id_aluop;
   logic        exm_regwrite, wb_regwrite;
   logic [4:0]  exm_rd, wb_rd;
   logic [31:0] exm_result, wb_result;
   logic        id_stall, ex_valid;
   logic [4:0]  ex_rd;
   logic        ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg;
   logic [2:0]  ex_aluop;
   logic [31:0] op_a, op_b, store_data;
   logic [4:0]  sh_amt;

   id_ex_stage #(.WIDTH(32), .REGBITS(5)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_shamt(id_shamt),
      .id_use_imm(id_use_imm), .id_shift_var(id_shift_var),
      .id_memread(id_memread), .id_memwrite(id_memwrite),
      .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_aluop(id_aluop),
      .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
      .id_stall(id_stall), .ex_valid(ex_valid), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_aluop(ex_aluop),
      .op_a(op_a), .op_b(op_b), .store_data(store_data), .sh_amt(sh_amt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [4:0]  rd;
      logic        memread;
      logic        regwrite;
      logic [31:0] a, b, sd;
      logic [4:0]  sh;
      logic        st;
   } exp_t;

   typedef struct {
      logic        valid;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rsd, rtd;
      logic [15:0] imm;
      logic [4:0]  shamt;
      logic        ui, sv;
      logic        exm_rw;
      logic [4:0]  exm_rd;
      logic [31:0] exm_res;
      logic        wb_rw;
      logic [4:0]  wb_rd;
      logic [31:0] wb_res;
      exp_t        e;
   } vec_t;

   exp_t sb[$];
   vec_t vt[11];
   int   errors = 0;
   int   checks = 0;

   function automatic exp_t mk(input logic v, input logic [4:0] rd, input logic mr, input logic rw,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                               input logic [4:0] sh, input logic st);
      exp_t e;
      e.valid = v; e.rd = rd; e.memread = mr; e.regwrite = rw;
      e.a = a; e.b = b; e.sd = sd; e.sh = sh; e.st = st;
      return e;
   endfunction

   function automatic vec_t mkv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                                input logic [15:0] imm, input logic [4:0] shamt,
                                input logic ui, input logic sv,
                                input logic xrw, input logic [4:0] xrd, input logic [31:0] xres,
                                input logic wrw, input logic [4:0] wrd, input logic [31:0] wres,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                                input logic [4:0] sh);
      vec_t t;
      t.valid = v; t.rs = rs; t.rt = rt; t.rd = rd; t.rsd = rsd; t.rtd = rtd;
      t.imm = imm; t.shamt = shamt; t.ui = ui; t.sv = sv;
      t.exm_rw = xrw; t.exm_rd = xrd; t.exm_res = xres;
      t.wb_rw = wrw; t.wb_rd = wrd; t.wb_res = wres;
      t.e = mk(v, rd, 1'b0, v, a, b, sd, sh, 1'b0);
      return t;
   endfunction

   task automatic cmp(input string tag, input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s: got %h expected %h", tag, name, act, req);
      end
   endtask

   task automatic check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s.scoreboard: got empty expected entry", tag);
         return;
      end
      e = sb.pop_front();
      cmp(tag, "ex_valid",    32'(ex_valid),    32'(e.valid));
      cmp(tag, "ex_rd",       32'(ex_rd),       32'(e.rd));
      cmp(tag, "ex_memread",  32'(ex_memread),  32'(e.memread));
      cmp(tag, "ex_regwrite", 32'(ex_regwrite), 32'(e.regwrite));
      cmp(tag, "op_a",        op_a,             e.a);
      cmp(tag, "op_b",        op_b,             e.b);
      cmp(tag, "store_data",  store_data,       e.sd);
      cmp(tag, "sh_amt",      32'(sh_amt),      32'(e.sh));
      cmp(tag, "id_stall",    32'(id_stall),    32'(e.st));
   endtask

   task automatic idle();
      stall = 0; flush = 0;
      id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
      id_use_imm = 0; id_shift_var = 0; id_memread = 0; id_memwrite = 0;
      id_regwrite = 0; id_memtoreg = 0; id_aluop = 0;
      exm_regwrite = 0; exm_rd = 0; exm_result = 0;
      wb_regwrite = 0; wb_rd = 0; wb_result = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // lw r4, 8(r1) with r1 = 0x10
   task automatic drive_lw(input logic [4:0] rd);
      idle();
      id_valid = 1; id_rs = 1; id_uses_rs = 1; id_rd = rd; id_rs_data = 32'h10;
      id_use_imm = 1; id_imm = 16'd8; id_memread = 1; id_regwrite = 1; id_memtoreg = 1;
   endtask

   // add r5, r4, r6
   task automatic drive_dep();
      idle();
      id_valid = 1; id_rs = 4; id_rt = 6; id_rd = 5; id_uses_rs = 1; id_uses_rt = 1;
      id_rs_data = 32'h99; id_rt_data = 32'h66; id_regwrite = 1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = mkv(1, 1, 2, 3,  32'h5,  32'h7,    16'h0,    5'd0,  0, 0,  0, 0, 0,            0, 0, 0,
                   32'h5, 32'h7, 32'h7, 5'd0);
      vt[1]  = mkv(1, 1, 2, 3,  32'h11, 32'h22,   16'h0,    5'd0,  0, 0,  1, 1, 32'h100,      1, 1, 32'h200,
                   32'h100, 32'h22, 32'h22, 5'd0);
      vt[2]  = mkv(1, 1, 2, 3,  32'h11, 32'h22,   16'h0,    5'd0,  0, 0,  0, 1, 32'h100,      1, 1, 32'h200,
                   32'h200, 32'h22, 32'h22, 5'd0);
      vt[3]  = mkv(1, 2, 3, 6,  32'h0,  32'h9,    16'h0,    5'd31, 0, 1,  1, 2, 32'hFFFF_FFE3, 0, 0, 0,
                   32'hFFFF_FFE3, 32'h9, 32'h9, 5'd3);
      vt[4]  = mkv(1, 2, 3, 6,  32'h40, 32'h9,    16'h0,    5'd5,  0, 0,  0, 0, 0,            0, 0, 0,
                   32'h40, 32'h9, 32'h9, 5'd5);
      vt[5]  = mkv(1, 1, 2, 7,  32'h1,  32'h1234, 16'h8000, 5'd0,  1, 0,  0, 0, 0,            0, 0, 0,
                   32'h1, 32'hFFFF_8000, 32'h1234, 5'd0);
      vt[6]  = mkv(1, 0, 0, 8,  32'h55, 32'h66,   16'h0,    5'd0,  0, 0,  1, 0, 32'hDEAD,     1, 0, 32'hBEEF,
                   32'h55, 32'h66, 32'h66, 5'd0);
      vt[7]  = mkv(1, 1, 7, 9,  32'h3,  32'h4,    16'h0,    5'd0,  0, 0,  1, 5, 32'hAA,       1, 7, 32'h777,
                   32'h3, 32'h777, 32'h777, 5'd0);
      vt[8]  = mkv(0, 1, 2, 10, 32'h9,  32'hA,    16'h0,    5'd0,  0, 0,  0, 0, 0,            0, 0, 0,
                   32'h9, 32'hA, 32'hA, 5'd0);
      vt[9]  = mkv(1, 3, 2, 11, 32'h25, 32'h2,    16'h7FFF, 5'd9,  1, 1,  0, 0, 0,            0, 0, 0,
                   32'h25, 32'h7FFF, 32'h2, 5'd5);
      vt[10] = mkv(1, 1, 4, 12, 32'h1,  32'h2,    16'h0,    5'd0,  0, 0,  1, 4, 32'hE,        1, 4, 32'hF,
                   32'h1, 32'hE, 32'hE, 5'd0);

      idle();
      reset = 1;
      #12;
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      check("reset");
      reset = 0;

      for (int i = 0; i < 11; i++) begin
         idle();
         id_valid = vt[i].valid; id_rs = vt[i].rs; id_rt = vt[i].rt; id_rd = vt[i].rd;
         id_uses_rs = 1; id_uses_rt = 1;
         id_rs_data = vt[i].rsd; id_rt_data = vt[i].rtd; id_imm = vt[i].imm; id_shamt = vt[i].shamt;
         id_use_imm = vt[i].ui; id_shift_var = vt[i].sv; id_regwrite = 1; id_aluop = 3'd2;
         exm_regwrite = vt[i].exm_rw; exm_rd = vt[i].exm_rd; exm_result = vt[i].exm_res;
         wb_regwrite = vt[i].wb_rw; wb_rd = vt[i].wb_rd; wb_result = vt[i].wb_res;
         sb.push_back(vt[i].e);
         step();
         check($sformatf("vec%0d", i));
      end

      // load-use: one bubble, then the dependent add enters with the load value forwarded
      drive_lw(5'd4);
      sb.push_back(mk(1, 4, 1, 1, 32'h10, 32'h8, 32'h0, 0, 0));
      step();
      check("lu_load");
      drive_dep();
      #1;
      cmp("lu_detect", "id_stall", 32'(id_stall), 32'd1);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      step();
      check("lu_bubble");
      exm_regwrite = 1; exm_rd = 4; exm_result = 32'h44;
      sb.push_back(mk(1, 5, 0, 1, 32'h44, 32'h66, 32'h66, 0, 0));
      step();
      check("lu_issue");

      // a load to r0 never creates a hazard
      drive_lw(5'd0);
      step();
      idle();
      id_valid = 1; id_rs = 0; id_uses_rs = 1; id_rd = 5;
      #1;
      cmp("lu_r0", "id_stall", 32'(id_stall), 32'd0);

      // stall together with a hazard: hold first, bubble on the first free edge
      drive_lw(5'd4);
      sb.push_back(mk(1, 4, 1, 1, 32'h10, 32'h8, 32'h0, 0, 0));
      step();
      check("sh_load");
      drive_dep();
      stall = 1;
      sb.push_back(mk(1, 4, 1, 1, 32'h10, 32'h8, 32'h0, 0, 1));
      step();
      check("sh_hold");
      stall = 0;
      #1;
      cmp("sh_pending", "id_stall", 32'(id_stall), 32'd1);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      step();
      check("sh_bubble");

      // reset in the middle of a hazard clears at once
      drive_lw(5'd4);
      step();
      drive_dep();
      #1;
      cmp("rh_detect", "id_stall", 32'(id_stall), 32'd1);
      reset = 1;
      #1;
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      check("rh_reset");
      #2;
      reset = 0;

      // flush beats stall
      idle();
      id_valid = 1; id_rs = 1; id_rt = 2; id_rd = 3; id_rs_data = 5; id_rt_data = 7; id_regwrite = 1;
      sb.push_back(mk(1, 3, 0, 1, 5, 7, 7, 0, 0));
      step();
      check("fl_load");
      id_rd = 9; id_rs_data = 32'h77;
      stall = 1; flush = 1;
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      step();
      check("fl_flush");

      // stall alone holds every EX output
      idle();
      id_valid = 1; id_rs = 1; id_rt = 2; id_rd = 3; id_rs_data = 5; id_rt_data = 7;
      id_regwrite = 1; id_shamt = 5'd6;
      sb.push_back(mk(1, 3, 0, 1, 5, 7, 7, 6, 0));
      step();
      check("st_load");
      id_rd = 9; id_rs_data = 32'h77; id_rt_data = 32'h88; id_shamt = 5'd1; id_regwrite = 0;
      stall = 1;
      sb.push_back(mk(1, 3, 0, 1, 5, 7, 7, 6, 1));
      step();
      check("st_hold1");
      sb.push_back(mk(1, 3, 0, 1, 5, 7, 7, 6, 1));
      step();
      check("st_hold2");
      stall = 0;
      sb.push_back(mk(1, 9, 0, 0, 32'h77, 32'h88, 32'h88, 1, 0));
      step();
      check("st_release");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
